// File: rtl/instr_fetch_queue.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : instr_fetch_queue                                               |
// | Purpose  : Circular instruction/PC queue between fetch and decode with     |
// |            first-word fall-through head and flush-to-empty.                |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module instr_fetch_queue #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 32
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [WIDTH-1:0]         instr_in,
   input  logic [WIDTH-1:0]         pc_in,
   input  logic                     in_valid,
   output logic                     stall,
   input  logic                     flush,
   input  logic                     out_ready,
   output logic                     out_valid,
   output logic [WIDTH-1:0]         instr_out,
   output logic [WIDTH-1:0]         pc_out,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int c_PTR_W = $clog2(DEPTH);
   localparam int c_CNT_W = c_PTR_W + 1;
   localparam logic [c_PTR_W-1:0] c_LAST_PTR = c_PTR_W'(DEPTH - 1);
   localparam logic [c_CNT_W-1:0] c_FULL     = c_CNT_W'(DEPTH);

   logic [2*WIDTH-1:0]  mem_q [DEPTH];
   logic [c_PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [c_PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [c_CNT_W-1:0]  count_q, count_d;
   logic                w_push;
   logic                w_pop;
   logic [2*WIDTH-1:0]  w_head;

   // Status flags come from registered occupancy only, so no input reaches them.
   assign stall     = (count_q == c_FULL);
   assign out_valid = (count_q != '0);
   assign count     = count_q;

   assign w_push = in_valid & ~stall & ~flush;
   assign w_pop  = out_valid & out_ready & ~flush;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (w_push) begin
            wr_ptr_d = (wr_ptr_q == c_LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
         end
         if (w_pop) begin
            rd_ptr_d = (rd_ptr_q == c_LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
         end
         case ({w_push, w_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage is deliberately unreset; the output mux hides it while empty.
   always_ff @(posedge clk) begin
      if (!rst && w_push) begin
         mem_q[wr_ptr_q] <= {instr_in, pc_in};
      end
   end

   assign w_head    = mem_q[rd_ptr_q];
   assign instr_out = out_valid ? w_head[2*WIDTH-1:WIDTH] : '0;
   assign pc_out    = out_valid ? w_head[WIDTH-1:0]       : '0;

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_queue.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_instr_fetch_queue                                            |
// | Purpose  : Directed self-checking bench for instr_fetch_queue (DEPTH=4).   |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_instr_fetch_queue;

   localparam int DEPTH = 4;
   localparam int WIDTH = 32;

   logic              clk;
   logic              rst;
   logic [WIDTH-1:0]  instr_in;
   logic [WIDTH-1:0]  pc_in;
   logic              in_valid;
   logic              stall;
   logic              flush;
   logic              out_ready;
   logic              out_valid;
   logic [WIDTH-1:0]  instr_out;
   logic [WIDTH-1:0]  pc_out;
   logic [2:0]        count;

   int n_cmp = 0;
   int n_err = 0;

   instr_fetch_queue #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
      .clk       (clk),
      .rst       (rst),
      .instr_in  (instr_in),
      .pc_in     (pc_in),
      .in_valid  (in_valid),
      .stall     (stall),
      .flush     (flush),
      .out_ready (out_ready),
      .out_valid (out_valid),
      .instr_out (instr_out),
      .pc_out    (pc_out),
      .count     (count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Advance one edge and settle just after it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [WIDTH-1:0] instr, input logic [WIDTH-1:0] pc);
      instr_in = instr;
      pc_in    = pc;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
   endtask

   initial begin
      rst       = 1'b0;
      instr_in  = '0;
      pc_in     = '0;
      in_valid  = 1'b0;
      flush     = 1'b0;
      out_ready = 1'b0;
      #1 rst = 1'b1;
      #1;
      check("rst_count", 64'(count), 64'd0);
      check("rst_valid", 64'(out_valid), 64'd0);
      check("rst_stall", 64'(stall), 64'd0);
      check("rst_instr", 64'(instr_out), 64'd0);
      check("rst_pc", 64'(pc_out), 64'd0);
      tick();
      rst = 1'b0;

      // Fill to full with decode holding off.
      push(32'h11, 32'h0);
      check("fill_cnt1", 64'(count), 64'd1);
      check("fill_head1", 64'(instr_out), 64'h11);
      push(32'h22, 32'h4);
      push(32'h33, 32'h8);
      check("fill_stall3", 64'(stall), 64'd0);
      push(32'h44, 32'hC);
      check("fill_cnt4", 64'(count), 64'd4);
      check("fill_stall4", 64'(stall), 64'd1);
      check("fill_head_pc", 64'(pc_out), 64'h0);
      push(32'h55, 32'h10);
      check("over_cnt", 64'(count), 64'd4);
      check("over_head", 64'(instr_out), 64'h11);

      // Drain in order.
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         check("drain_instr", 64'(instr_out), 64'(32'h11 * (i + 1)));
         check("drain_pc", 64'(pc_out), 64'(4 * i));
         tick();
      end
      check("drain_valid", 64'(out_valid), 64'd0);
      check("drain_instr0", 64'(instr_out), 64'd0);
      check("drain_cnt", 64'(count), 64'd0);
      tick();
      check("empty_pop_cnt", 64'(count), 64'd0);

      // Empty with push and pop together: only the push lands.
      out_ready = 1'b1;
      push(32'h100, 32'h200);
      check("empty_pp_cnt", 64'(count), 64'd1);
      check("empty_pp_head", 64'(instr_out), 64'h100);
      out_ready = 1'b0;
      push(32'h101, 32'h204);
      check("conc_start_cnt", 64'(count), 64'd2);

      // Steady push/pop at count 2 across pointer wrap.
      out_ready = 1'b1;
      in_valid  = 1'b1;
      for (int i = 0; i < 10; i++) begin
         instr_in = 32'h102 + i;
         pc_in    = 32'h208 + 4 * i;
         check("conc_head", 64'(instr_out), 64'(32'h100 + i));
         check("conc_pc", 64'(pc_out), 64'(32'h200 + 4 * i));
         tick();
         check("conc_cnt", 64'(count), 64'd2);
      end
      in_valid  = 1'b0;
      out_ready = 1'b0;

      // Full plus pop: the offered entry must not be stored.
      push(32'h200, 32'h0);
      push(32'h201, 32'h0);
      check("fp_full", 64'(stall), 64'd1);
      out_ready = 1'b1;
      push(32'h300, 32'h0);
      check("fp_cnt", 64'(count), 64'd3);
      check("fp_stall", 64'(stall), 64'd0);
      check("fp_head", 64'(instr_out), 64'h10B);
      tick();
      check("fp_seq1", 64'(instr_out), 64'h200);
      tick();
      check("fp_seq2", 64'(instr_out), 64'h201);
      tick();
      check("fp_empty", 64'(out_valid), 64'd0);
      out_ready = 1'b0;

      // Flush beats push and pop.
      push(32'h400, 32'h0);
      push(32'h401, 32'h0);
      push(32'h402, 32'h0);
      check("fl_cnt3", 64'(count), 64'd3);
      flush     = 1'b1;
      out_ready = 1'b1;
      push(32'h500, 32'h0);
      flush     = 1'b0;
      out_ready = 1'b0;
      check("fl_cnt", 64'(count), 64'd0);
      check("fl_valid", 64'(out_valid), 64'd0);
      check("fl_stall", 64'(stall), 64'd0);
      check("fl_instr", 64'(instr_out), 64'd0);
      push(32'h99, 32'h40);
      check("fl_push_cnt", 64'(count), 64'd1);
      check("fl_push_head", 64'(instr_out), 64'h99);
      check("fl_push_pc", 64'(pc_out), 64'h40);

      // Async reset between edges.
      push(32'h98, 32'h44);
      check("ar_cnt2", 64'(count), 64'd2);
      #3 rst = 1'b1;
      #1;
      check("ar_cnt", 64'(count), 64'd0);
      check("ar_valid", 64'(out_valid), 64'd0);
      check("ar_instr", 64'(instr_out), 64'd0);
      out_ready = 1'b1;
      push(32'h66, 32'h0);
      check("ar_hold_cnt", 64'(count), 64'd0);
      rst = 1'b0;
      out_ready = 1'b0;
      push(32'h77, 32'h80);
      check("ar_first_cnt", 64'(count), 64'd1);
      check("ar_first_head", 64'(instr_out), 64'h77);
      out_ready = 1'b1;
      tick();
      check("ar_final_valid", 64'(out_valid), 64'd0);
      check("ar_final_cnt", 64'(count), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/instr_fetch_queue.md
INSTR_FETCH_QUEUE -- requirements
Module: instr_fetch_queue

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, number of queue entries; legal values are 2, 4 and 8.
REQ-002 The block SHALL have parameter WIDTH, default 32, instruction and PC width in bits.
REQ-003 The block SHALL have port clk, input, 1 bit, single clock; all state updates on rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit, reset, asynchronous and active-high.
REQ-005 The block SHALL have port instr_in, input, WIDTH bits, instruction word from the fetch phase.
REQ-006 The block SHALL have port pc_in, input, WIDTH bits, PC of instr_in.
REQ-007 The block SHALL have port in_valid, input, 1 bit, fetch phase presents instr_in/pc_in this cycle.
REQ-008 The block SHALL have port stall, output, 1 bit, queue full; fetch holds its PC and data.
REQ-009 The block SHALL have port flush, input, 1 bit, branch taken; discard all queued entries.
REQ-010 The block SHALL have port out_ready, input, 1 bit, decode phase accepts the head entry this cycle.
REQ-011 The block SHALL have port out_valid, output, 1 bit, head entry present.
REQ-012 The block SHALL have port instr_out, output, WIDTH bits, head instruction.
REQ-013 The block SHALL have port pc_out, output, WIDTH bits, head PC.
REQ-014 The block SHALL have port count, output, log2(DEPTH)+1 bits, current occupancy.

Function
REQ-015 The block SHALL be a circular buffer with a write pointer, a read pointer and an occupancy counter; pointers SHALL wrap from DEPTH-1 to 0.
REQ-016 The block SHALL assert stall exactly when count == DEPTH; stall SHALL be derived from registered count only, with no combinational path from any input.
REQ-017 A push SHALL occur when in_valid=1 and stall=0 and flush=0; it writes {instr_in, pc_in} at the write pointer and advances that pointer.
REQ-018 When stall=1, the block SHALL ignore in_valid and leave storage unchanged; a same-cycle pop SHALL NOT free a slot for a push in that cycle.
REQ-019 The block SHALL assert out_valid exactly when count != 0 (first-word fall-through): the head entry appears on instr_out/pc_out in the cycle after its push, so push-to-visible latency is 1 cycle.
REQ-020 A pop SHALL occur when out_valid=1 and out_ready=1 and flush=0; it advances the read pointer.
REQ-021 out_ready while out_valid=0 SHALL have no effect, and count SHALL never underflow.
REQ-022 A simultaneous push and pop with 0 < count < DEPTH SHALL leave count unchanged and advance both pointers.
REQ-023 When count=0 and a push and a pop request coincide, only the push SHALL take effect, because no pop is possible while out_valid=0.
REQ-024 The block SHALL drive instr_out and pc_out to 0 whenever out_valid=0.
REQ-025 flush=1 SHALL take priority over push and pop; on the next edge count, the write pointer and the read pointer SHALL all be 0, and the same-cycle in_valid data SHALL be discarded.
REQ-026 After a flush, out_valid SHALL be 0 and stall SHALL be 0 in the following cycle.
REQ-027 The entry order at the output SHALL equal push order; no entry SHALL be duplicated or dropped except by flush or reset.
REQ-028 Storage contents need not be reset; they SHALL never be observable while out_valid=0.

Reset
REQ-029 Assertion of rst SHALL immediately, without waiting for a clock edge, force count=0, both pointers=0, out_valid=0, stall=0, instr_out=0 and pc_out=0.
REQ-030 While rst=1, all pushes, pops and flushes SHALL be ignored.
REQ-031 After rst deasserts, the first push SHALL be accepted on the first rising edge at which in_valid=1.
REQ-032 Reset asserted mid-operation, with a partially full or full queue, SHALL discard all entries exactly as in REQ-029.

Verification
REQ-033 Fill test: DEPTH=4, out_ready=0, push instr 0x11,0x22,0x33,0x44 with pc 0x0,0x4,0x8,0xC -> count=4 and stall=1 after the 4th edge; a 5th push of 0x55 is ignored.
REQ-034 Drain order: from the full state of REQ-033, out_ready=1 for 4 cycles -> instr_out reads 0x11,0x22,0x33,0x44 in order, then out_valid=0 and instr_out=0.
REQ-035 Concurrent push/pop: count=2, in_valid=1 and out_ready=1 for 10 cycles -> count stays 2 and the output sequence is the input sequence delayed by 2 entries, across pointer wrap.
REQ-036 Full plus pop: count=4, in_valid=1 and out_ready=1 in the same cycle -> count becomes 3 and the offered entry is not stored.
REQ-037 Flush priority: count=3, flush=1 with in_valid=1 and out_ready=1 -> next cycle count=0, out_valid=0, stall=0; the next push of 0x99 appears at the head with count=1.
REQ-038 Async reset: count=2, rst pulsed between clock edges -> out_valid=0 and count=0 before the next edge; no previously queued entry reappears afterwards.
